// File: rtl/regfile_sb.sv
// regfile_sb: integer register file (x1-x31) with combinational read ports,
// same-cycle writeback bypass, and a per-register outstanding-write scoreboard
// that lets issue stall on RAW hazards. x0 is hardwired to zero and never tracked.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int MAX_PEND = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [4:0]      rd_i,
   input  logic [XLEN-1:0] rd_data,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            issue_en,
   input  logic [4:0]      issue_rd,
   output logic            issue_ready,
   input  logic            flush
);

   localparam logic [1:0] PEND_MAX_C = 2'(MAX_PEND);
   localparam logic [4:0] X0_C       = 5'd0;

   // Architectural state: data and pending-write counters for x1..x31 only.
   logic [XLEN-1:0] regs_q [1:31];
   logic [XLEN-1:0] regs_d [1:31];
   logic [1:0]      pend_q [1:31];
   logic [1:0]      pend_d [1:31];

   logic [XLEN-1:0] rs1_store_s;
   logic [XLEN-1:0] rs2_store_s;
   logic [1:0]      rs1_pend_s;
   logic [1:0]      rs2_pend_s;
   logic [1:0]      wr_pend_s;
   logic [1:0]      iss_pend_s;
   logic            wr_nz_s;
   logic            dec_s;
   logic            inc_s;
   logic            rs1_dec_s;
   logic            rs2_dec_s;

   // Look up stored data and pending counts for every addressed register; x0 reads as empty.
   always_comb begin
      rs1_store_s = '0;
      rs2_store_s = '0;
      rs1_pend_s  = 2'd0;
      rs2_pend_s  = 2'd0;
      wr_pend_s   = 2'd0;
      iss_pend_s  = 2'd0;
      if (rs1_addr != X0_C) begin
         rs1_store_s = regs_q[rs1_addr];
         rs1_pend_s  = pend_q[rs1_addr];
      end else begin
         rs1_store_s = '0;
         rs1_pend_s  = 2'd0;
      end
      if (rs2_addr != X0_C) begin
         rs2_store_s = regs_q[rs2_addr];
         rs2_pend_s  = pend_q[rs2_addr];
      end else begin
         rs2_store_s = '0;
         rs2_pend_s  = 2'd0;
      end
      if (rd_i != X0_C) begin
         wr_pend_s = pend_q[rd_i];
      end else begin
         wr_pend_s = 2'd0;
      end
      if (issue_rd != X0_C) begin
         iss_pend_s = pend_q[issue_rd];
      end else begin
         iss_pend_s = 2'd0;
      end
   end

   // Writeback/issue handshake, bypassed read data and same-cycle-resolved busy flags.
   always_comb begin
      wr_nz_s     = wr_en & (rd_i != X0_C);
      // A writeback only retires a tracked write when one is outstanding (no underflow).
      dec_s       = wr_nz_s & (wr_pend_s != 2'd0);
      issue_ready = (issue_rd == X0_C) | (iss_pend_s < PEND_MAX_C) |
                    (dec_s & (rd_i == issue_rd));
      inc_s       = issue_en & issue_ready & (issue_rd != X0_C);
      rs1_dec_s   = dec_s & (rd_i == rs1_addr);
      rs2_dec_s   = dec_s & (rd_i == rs2_addr);
      if (wr_nz_s && (rd_i == rs1_addr)) begin
         rs1_data = rd_data;
      end else begin
         rs1_data = rs1_store_s;
      end
      if (wr_nz_s && (rd_i == rs2_addr)) begin
         rs2_data = rd_data;
      end else begin
         rs2_data = rs2_store_s;
      end
      // The retiring writeback is subtracted so busy drops in the same cycle as the bypass.
      rs1_busy = (rs1_addr != X0_C) & ((rs1_pend_s - {1'b0, rs1_dec_s}) != 2'd0);
      rs2_busy = (rs2_addr != X0_C) & ((rs2_pend_s - {1'b0, rs2_dec_s}) != 2'd0);
   end

   // Next-state: data write, and counter update where flush beats inc/dec and inc+dec cancel.
   always_comb begin
      for (int r = 1; r < 32; r++) begin
         regs_d[r] = regs_q[r];
         pend_d[r] = pend_q[r];
         if (wr_nz_s && (rd_i == 5'(r))) begin
            regs_d[r] = rd_data;
         end else begin
            regs_d[r] = regs_q[r];
         end
         if (flush) begin
            pend_d[r] = 2'd0;
         end else if (inc_s && (issue_rd == 5'(r)) && !(dec_s && (rd_i == 5'(r)))) begin
            pend_d[r] = pend_q[r] + 2'd1;
         end else if (dec_s && (rd_i == 5'(r)) && !(inc_s && (issue_rd == 5'(r)))) begin
            pend_d[r] = pend_q[r] - 2'd1;
         end else begin
            pend_d[r] = pend_q[r];
         end
      end
   end

   // State registers; asynchronous reset clears all data and pending state at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < 32; r++) begin
            regs_q[r] <= '0;
            pend_q[r] <= 2'd0;
         end
      end else begin
         for (int r = 1; r < 32; r++) begin
            regs_q[r] <= regs_d[r];
            pend_q[r] <= pend_d[r];
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus randomized traffic against a
// behavioural model; expectations flow through a scoreboard queue.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  rd_i;
   logic [31:0] rd_data;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic        flush;

   regfile_sb #(.XLEN(32), .MAX_PEND(3)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_i(rd_i), .rd_data(rd_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue_en(issue_en), .issue_rd(issue_rd),
      .issue_ready(issue_ready), .flush(flush)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic        iss;
      logic [4:0]  ird;
      logic        fl;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        b1;
      logic        b2;
      logic        rdy;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        b1;
      logic        b2;
      logic        rdy;
   } exp_t;

   exp_t        sb_q[$];
   vec_t        tbl[$];
   int          checks;
   int          failures;
   logic [31:0] m_reg[32];
   int          m_pend[32];

   // Free-running core clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic we, input logic [4:0] rd,
                               input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                               input logic iss, input logic [4:0] ird, input logic fl,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic b1, input logic b2, input logic rdy);
      vec_t v;
      v.name = n; v.we = we; v.rd = rd; v.wd = wd; v.a1 = a1; v.a2 = a2;
      v.iss = iss; v.ird = ird; v.fl = fl;
      v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2; v.rdy = rdy;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = 32'd0;
         m_pend[i] = 0;
      end
   endtask

   function automatic exp_t model_exp(input vec_t v);
      exp_t e;
      bit   dec;
      dec    = v.we && (v.rd != 5'd0) && (m_pend[v.rd] > 0);
      e.name = v.name;
      e.e1   = (v.a1 == 5'd0) ? 32'd0 : ((v.we && v.rd == v.a1) ? v.wd : m_reg[v.a1]);
      e.e2   = (v.a2 == 5'd0) ? 32'd0 : ((v.we && v.rd == v.a2) ? v.wd : m_reg[v.a2]);
      e.b1   = (v.a1 != 5'd0) && ((m_pend[v.a1] - ((dec && v.rd == v.a1) ? 1 : 0)) > 0);
      e.b2   = (v.a2 != 5'd0) && ((m_pend[v.a2] - ((dec && v.rd == v.a2) ? 1 : 0)) > 0);
      e.rdy  = (v.ird == 5'd0) || (m_pend[v.ird] < 3) || (dec && v.rd == v.ird);
      return e;
   endfunction

   task automatic model_step(input vec_t v);
      bit   dec;
      bit   inc;
      exp_t e;
      e   = model_exp(v);
      dec = v.we && (v.rd != 5'd0) && (m_pend[v.rd] > 0);
      inc = v.iss && e.rdy && (v.ird != 5'd0);
      if (v.we && v.rd != 5'd0) m_reg[v.rd] = v.wd;
      if (v.fl) begin
         for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else begin
         if (inc) m_pend[v.ird] = m_pend[v.ird] + 1;
         if (dec) m_pend[v.rd] = m_pend[v.rd] - 1;
      end
   endtask

   // Drive one cycle: push expectation, compare at the falling edge, advance model at the edge.
   task automatic run_cycle(input vec_t v, input bit use_model);
      exp_t e;
      exp_t got;
      wr_en = v.we; rd_i = v.rd; rd_data = v.wd; rs1_addr = v.a1; rs2_addr = v.a2;
      issue_en = v.iss; issue_rd = v.ird; flush = v.fl;
      if (use_model) begin
         e = model_exp(v);
      end else begin
         e.name = v.name; e.e1 = v.e1; e.e2 = v.e2; e.b1 = v.b1; e.b2 = v.b2; e.rdy = v.rdy;
      end
      sb_q.push_back(e);
      @(negedge clk);
      got = sb_q.pop_front();
      chk({got.name, ".rs1_data"}, rs1_data, got.e1);
      chk({got.name, ".rs2_data"}, rs2_data, got.e2);
      chk({got.name, ".rs1_busy"}, {31'd0, rs1_busy}, {31'd0, got.b1});
      chk({got.name, ".rs2_busy"}, {31'd0, rs2_busy}, {31'd0, got.b2});
      chk({got.name, ".issue_ready"}, {31'd0, issue_ready}, {31'd0, got.rdy});
      model_step(v);
      @(posedge clk);
      #1;
   endtask

   // Main test sequence.
   initial begin
      vec_t v;
      checks = 0; failures = 0;
      rst_n = 1'b0; wr_en = 1'b0; rd_i = 5'd0; rd_data = 32'd0; rs1_addr = 5'd0;
      rs2_addr = 5'd0; issue_en = 1'b0; issue_rd = 5'd0; flush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a); rs2_addr = 5'(31 - a); issue_rd = 5'(a);
         #1;
         chk("reset.rs1_data", rs1_data, 32'd0);
         chk("reset.rs2_data", rs2_data, 32'd0);
         chk("reset.rs1_busy", {31'd0, rs1_busy}, 32'd0);
         chk("reset.rs2_busy", {31'd0, rs2_busy}, 32'd0);
         chk("reset.issue_ready", {31'd0, issue_ready}, 32'd1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      //                name          we    rd     wd            a1     a2     iss   ird    fl    e1            e2            b1    b2    rdy
      tbl.push_back(mk("x0_write",    1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("x0_issue",    1'b0, 5'd0,  32'd0,        5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("x0_read",     1'b0, 5'd0,  32'd0,        5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("bypass",      1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("bypass_next", 1'b0, 5'd0,  32'd0,        5'd7,  5'd7,  1'b0, 5'd0,  1'b0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("raw_issue",   1'b0, 5'd0,  32'd0,        5'd3,  5'd0,  1'b1, 5'd3,  1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("raw_c1",      1'b0, 5'd0,  32'd0,        5'd3,  5'd0,  1'b0, 5'd3,  1'b0, 32'd0,        32'd0,        1'b1, 1'b0, 1'b1));
      tbl.push_back(mk("raw_c2",      1'b0, 5'd0,  32'd0,        5'd3,  5'd0,  1'b0, 5'd3,  1'b0, 32'd0,        32'd0,        1'b1, 1'b0, 1'b1));
      tbl.push_back(mk("raw_c3",      1'b0, 5'd0,  32'd0,        5'd3,  5'd0,  1'b0, 5'd3,  1'b0, 32'd0,        32'd0,        1'b1, 1'b0, 1'b1));
      tbl.push_back(mk("raw_wb",      1'b1, 5'd3,  32'h000000A5, 5'd3,  5'd0,  1'b0, 5'd3,  1'b0, 32'h000000A5, 32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("raw_after",   1'b0, 5'd0,  32'd0,        5'd3,  5'd0,  1'b0, 5'd3,  1'b0, 32'h000000A5, 32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("sat_iss1",    1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("sat_iss2",    1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 32'd0,        32'd0,        1'b1, 1'b0, 1'b1));
      tbl.push_back(mk("sat_iss3",    1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 32'd0,        32'd0,        1'b1, 1'b0, 1'b1));
      tbl.push_back(mk("sat_iss4",    1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 32'd0,        32'd0,        1'b1, 1'b0, 1'b0));
      tbl.push_back(mk("sat_hold",    1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b0, 5'd9,  1'b0, 32'd0,        32'd0,        1'b1, 1'b0, 1'b0));
      tbl.push_back(mk("sat_wb_iss",  1'b1, 5'd9,  32'h00000099, 5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 32'h00000099, 32'd0,        1'b1, 1'b0, 1'b1));
      tbl.push_back(mk("sat_still3",  1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b0, 5'd9,  1'b0, 32'h00000099, 32'd0,        1'b1, 1'b0, 1'b0));
      tbl.push_back(mk("drain1",      1'b1, 5'd9,  32'd1,        5'd9,  5'd0,  1'b0, 5'd9,  1'b0, 32'd1,        32'd0,        1'b1, 1'b0, 1'b1));
      tbl.push_back(mk("drain2",      1'b1, 5'd9,  32'd2,        5'd9,  5'd0,  1'b0, 5'd9,  1'b0, 32'd2,        32'd0,        1'b1, 1'b0, 1'b1));
      tbl.push_back(mk("drain3",      1'b1, 5'd9,  32'd3,        5'd9,  5'd0,  1'b0, 5'd9,  1'b0, 32'd3,        32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("wb_pend0",    1'b1, 5'd9,  32'd4,        5'd9,  5'd0,  1'b0, 5'd9,  1'b0, 32'd4,        32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("no_uflow",    1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b1, 5'd9,  1'b0, 32'd4,        32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("pend_one",    1'b0, 5'd0,  32'd0,        5'd9,  5'd0,  1'b0, 5'd9,  1'b0, 32'd4,        32'd0,        1'b1, 1'b0, 1'b1));
      tbl.push_back(mk("fl_iss1",     1'b0, 5'd0,  32'd0,        5'd4,  5'd9,  1'b1, 5'd4,  1'b0, 32'd0,        32'd4,        1'b0, 1'b1, 1'b1));
      tbl.push_back(mk("fl_iss2",     1'b0, 5'd0,  32'd0,        5'd4,  5'd9,  1'b1, 5'd4,  1'b0, 32'd0,        32'd4,        1'b1, 1'b1, 1'b1));
      tbl.push_back(mk("flush_wb",    1'b1, 5'd4,  32'h00000055, 5'd4,  5'd9,  1'b0, 5'd4,  1'b1, 32'h00000055, 32'd4,        1'b1, 1'b1, 1'b1));
      tbl.push_back(mk("after_flush", 1'b0, 5'd0,  32'd0,        5'd4,  5'd9,  1'b0, 5'd4,  1'b0, 32'h00000055, 32'd4,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("flush_iss",   1'b0, 5'd0,  32'd0,        5'd4,  5'd0,  1'b1, 5'd4,  1'b1, 32'h00000055, 32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("fl_iss_drop", 1'b0, 5'd0,  32'd0,        5'd4,  5'd0,  1'b0, 5'd4,  1'b0, 32'h00000055, 32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("x5_write",    1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  1'b1, 5'd6,  1'b0, 32'hDEADBEEF, 32'd0,        1'b0, 1'b0, 1'b1));
      tbl.push_back(mk("x5_read",     1'b0, 5'd0,  32'd0,        5'd5,  5'd6,  1'b0, 5'd6,  1'b0, 32'hDEADBEEF, 32'd0,        1'b0, 1'b1, 1'b1));

      foreach (tbl[i]) run_cycle(tbl[i], 1'b0);

      // Mid-operation reset: stored data and pending state vanish without a clock edge.
      wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst.rs1_data", rs1_data, 32'd0);
      chk("midrst.rs2_busy", {31'd0, rs2_busy}, 32'd0);
      chk("midrst.issue_ready", {31'd0, issue_ready}, 32'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_cycle(mk("post_rst", 1'b0, 5'd0, 32'd0, 5'd5, 5'd6, 1'b0, 5'd6, 1'b0,
                   32'd0, 32'd0, 1'b0, 1'b0, 1'b1), 1'b0);

      // Randomized traffic over a small address set to force collisions.
      for (int n = 0; n < 400; n++) begin
         v.name = "rand";
         v.we   = 1'($urandom_range(0, 1));
         v.rd   = 5'($urandom_range(0, 7));
         v.wd   = $urandom;
         v.a1   = 5'($urandom_range(0, 7));
         v.a2   = 5'($urandom_range(0, 7));
         v.iss  = 1'($urandom_range(0, 1));
         v.ird  = 5'($urandom_range(0, 7));
         v.fl   = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
         v.e1 = 32'd0; v.e2 = 32'd0; v.b1 = 1'b0; v.b2 = 1'b0; v.rdy = 1'b0;
         run_cycle(v, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Integer register file with an in-order write scoreboard. It is the receiving end of the writeback interface: it accepts `wr_en`/`rd`/`rd_data` writes and serves two combinational read ports to decode/issue. It also tracks outstanding writes per register so issue can stall on RAW hazards. It sits between the writeback unit and the decode/issue stage of the core.

## Interface
Parameters:
- `XLEN`, 32, data width of each register.
- `MAX_PEND`, 3, maximum outstanding writes tracked per register (2-bit counters; legal range 1–3).

Ports:
- `clk`, input, 1, core clock; all state updates on the rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `wr_en`, input, 1, writeback write strobe.
- `rd_i`, input, 5, writeback destination register.
- `rd_data`, input, XLEN, writeback data.
- `rs1_addr`, input, 5, read port 1 address.
- `rs2_addr`, input, 5, read port 2 address.
- `rs1_data`, output, XLEN, read port 1 data.
- `rs2_data`, output, XLEN, read port 2 data.
- `rs1_busy`, output, 1, rs1 has an unresolved outstanding write.
- `rs2_busy`, output, 1, rs2 has an unresolved outstanding write.
- `issue_en`, input, 1, an instruction writing `issue_rd` issues this cycle.
- `issue_rd`, input, 5, destination of the issuing instruction.
- `issue_ready`, output, 1, the pending counter of `issue_rd` can accept another issue.
- `flush`, input, 1, discard all outstanding-write tracking (pipeline flush).

## Operation
- Storage: 31 × XLEN registers for x1–x31. x0 is not stored.
- x0:
  - Reads return 0.
  - Writes are ignored.
  - Issues are never counted.
  - Busy is always 0.
- Write: when `wr_en`=1 and `rd_i`≠0, `rd_data` is stored at the rising edge.
- Read bypass: if `wr_en`=1, `rd_i`≠0 and `rd_i`==`rsN_addr`, then `rsN_data`=`rd_data` in the same cycle. Otherwise `rsN_data` is the stored value.
- Scoreboard: one counter `pend[r]` per register, range 0..MAX_PEND.
  - inc = `issue_en` & `issue_ready` & (`issue_rd`≠0).
  - dec = `wr_en` & (`rd_i`≠0) & (`pend[rd_i]`>0).
  - inc and dec on the same register in the same cycle: counter unchanged.
  - dec with `pend`=0: no underflow. The data write still happens.
  - Issue while `issue_ready`=0: ignored. The counter does not change and issue logic must stall.
- `issue_ready` = (`issue_rd`==0) | (`pend[issue_rd]`<MAX_PEND) | (dec targets `issue_rd` this cycle).
- `rsN_busy` = (`rsN_addr`≠0) & (`pend[rsN_addr]` − (dec on `rsN_addr` ? 1 : 0) > 0).
  - A writeback that clears the last pending write is visible as not-busy in the same cycle, consistent with the data bypass.
- `flush`=1: all counters go to 0 at the edge. Flush overrides inc/dec. The register data write in that cycle still occurs.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - All registers are 0 and all counters are 0.
  - Outputs therefore settle to: `rs1_data`=`rs2_data`=0, `rs1_busy`=`rs2_busy`=0, `issue_ready`=1.
  - Reset asserted mid-operation discards all data and pending state immediately.
  - Deassertion is sampled synchronously; the first update occurs on the first rising edge after release.
- Read data and busy: zero-cycle combinational from addresses, including bypass.
- Write: visible through bypass in cycle N, and from storage from cycle N+1.
- Issue: counter increments at the edge. Busy becomes visible to readers in cycle N+1, never in the issue cycle itself.
- Flush: busy outputs read 0 from cycle N+1.

## Test plan
- **Reset.** Hold `rst_n`=0, read all 32 addresses -> data 0, busy 0, `issue_ready`=1. Pulse `rst_n` low after writing x5=0xDEADBEEF -> x5 reads 0 immediately.
- **x0.** Write x0=0xFFFFFFFF, then `issue_en` with `issue_rd`=0 -> x0 reads 0, `rs1_busy`=0 for x0, `issue_ready`=1.
- **Bypass.** `wr_en`=1, `rd_i`=7, `rd_data`=0x12345678 with `rs1_addr`=`rs2_addr`=7 in the same cycle -> both ports read 0x12345678 that cycle and on the following cycle with `wr_en`=0.
- **Scoreboard RAW.**
  - Issue x3 in cycle 0 -> `rs1_busy`=1 for x3 from cycle 1.
  - Writeback x3=0xA5 in cycle 4 -> `rs1_busy`=0 and data 0xA5 in cycle 4.
- **Saturation.**
  - Issue x9 three times -> `issue_ready`=0 for x9, and a fourth issue does not change state.
  - Writeback x9 in the same cycle as a fourth issue -> `issue_ready`=1 and the counter stays 3.
- **Flush and simultaneous events.**
  - With x4 pending=2, assert `flush` together with `wr_en` to x4=0x55 -> busy 0 next cycle and x4 reads 0x55.
  - Writeback to a register with pend=0 -> data written, no counter change.
